blob_requant_stage: RTL and testbench



---
 rtl/blob_pkg.sv | 32 +++
 rtl/blob_sync_fifo.sv | 63 ++++++
 rtl/blob_requant_stage.sv | 132 +++++++++++++
 tb/tb_blob_requant_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared constants and the per-lane round/shift/saturate helper for the blob
// requantization datapath.
`timescale 1ns/1ps
package blob_pkg;

  localparam int BLOB_LANES  = 8;
  localparam int BLOB_DIN_W  = 8;
  localparam int BLOB_DOUT_W = 8;

  // Rounded arithmetic right shift (round half up), then clamp to a signed
  // dout_w range; relu forces negatives to zero after the clamp. Integer
  // arithmetic is wide enough that the rounding add never overflows.
  function automatic int lane_requant(input int x, input int shift,
                                      input int dout_w, input bit relu);
    int y;
    int hi;
    int lo;
    y  = (shift == 0) ? x : ((x + (1 << (shift - 1))) >>> shift);
    hi = (1 << (dout_w - 1)) - 1;
    lo = -(1 << (dout_w - 1));
    if (y > hi) begin
      y = hi;
    end else if (y < lo) begin
      y = lo;
    end
    if (relu && (y < 0)) begin
      y = 0;
    end
    return y;
  endfunction

endpackage

// File: rtl/blob_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may occur together.
// The head word is presented combinationally on o_data.
`timescale 1ns/1ps
module blob_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // NOTE: storage has no reset; an entry is only ever read after it was written,
  // and the empty head is masked by the consumer.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/blob_requant_stage.sv
// Requantizes the pooled blob stream lane by lane, checks frame length and
// re-emits it through a credit-controlled output FIFO.
// Define BLOB_REQUANT_RELU_EN to fuse a ReLU after saturation.
`timescale 1ns/1ps
module blob_requant_stage
  import blob_pkg::*;
#(
  parameter int LANES           = BLOB_LANES,
  parameter int DIN_W           = BLOB_DIN_W,
  parameter int DOUT_W          = BLOB_DOUT_W,
  parameter int SHIFT           = 0,
  parameter int WORDS_PER_FRAME = 256,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blob_din_en,
  output logic                    blob_din_rdy,
  input  logic                    blob_din_eop,
  input  logic [LANES*DIN_W-1:0]  blob_din,
  input  logic                    blob_dout_rdy,
  output logic                    blob_dout_en,
  output logic                    blob_dout_eop,
  output logic [LANES*DOUT_W-1:0] blob_dout,
  output logic                    frame_err
);

  localparam int DW     = LANES * DOUT_W;
  localparam int FW     = DW + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCNT_W = $clog2(WORDS_PER_FRAME);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

`ifdef BLOB_REQUANT_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  logic              w_accept;
  logic [DW-1:0]     w_lane_word;
  logic              r_s1_valid;
  logic              r_s1_eop;
  logic [DW-1:0]     r_s1_data;
  logic [FW-1:0]     w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_pop;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_next;
  logic              r_frame_err;
  logic              w_err_set;

  // Credit is computed from registers only, so downstream ready never reaches
  // upstream ready combinationally.
  assign blob_din_rdy = (CNT_W'(r_s1_valid) + w_fifo_count) < CNT_W'(FIFO_DEPTH);
  assign w_accept     = blob_din_en && blob_din_rdy;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_word[g*DOUT_W +: DOUT_W] =
      DOUT_W'(lane_requant(int'(signed'(blob_din[g*DIN_W +: DIN_W])),
                           SHIFT, DOUT_W, RELU_EN));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_eop  <= blob_din_eop;
        r_s1_data <= w_lane_word;
      end
    end
  end

  // s1 drains unconditionally; the credit rule guarantees a free entry.
  blob_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s1_valid),
    .i_data  ({r_s1_eop, r_s1_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign w_pop         = !w_fifo_empty && blob_dout_rdy;
  assign blob_dout_en  = w_pop;
  assign blob_dout     = w_fifo_empty ? '0 : w_fifo_head[DW-1:0];
  assign blob_dout_eop = !w_fifo_empty && w_fifo_head[DW];

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    w_wcnt_next = r_wcnt;
    w_err_set   = 1'b0;
    if (w_accept) begin
      if (r_wcnt == LAST_WORD) begin
        w_wcnt_next = '0;
        w_err_set   = !blob_din_eop;
      end else if (blob_din_eop) begin
        w_wcnt_next = '0;
        w_err_set   = 1'b1;
      end else begin
        w_wcnt_next = r_wcnt + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wcnt <= w_wcnt_next;
      if (w_err_set) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_blob_requant_stage.sv
// Scoreboard bench: two instances (SHIFT=1/DOUT_W=8 and SHIFT=2/DOUT_W=4) share
// one input stream; accepted words push expectations, monitors pop on output.
`timescale 1ns/1ps
module tb_blob_requant_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_en;
  logic        din_eop;
  logic [63:0] din;
  logic        dout_rdy;
  logic        rdy_a, en_a, eop_a, err_a;
  logic [63:0] dout_a;
  logic        rdy_b, en_b, eop_b, err_b;
  logic [31:0] dout_b;

  always #5 clk = ~clk;

  blob_requant_stage #(.SHIFT(1), .DOUT_W(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .blob_din_en(din_en), .blob_din_rdy(rdy_a), .blob_din_eop(din_eop), .blob_din(din),
    .blob_dout_rdy(dout_rdy), .blob_dout_en(en_a), .blob_dout_eop(eop_a),
    .blob_dout(dout_a), .frame_err(err_a)
  );

  blob_requant_stage #(.SHIFT(2), .DOUT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .blob_din_en(din_en), .blob_din_rdy(rdy_b), .blob_din_eop(din_eop), .blob_din(din),
    .blob_dout_rdy(dout_rdy), .blob_dout_en(en_b), .blob_dout_eop(eop_b),
    .blob_dout(dout_b), .frame_err(err_b)
  );

  // Hand-computed vectors (lane 0 in the low byte).
  localparam logic [63:0] VEC0 = 64'h02FF_00C0_01FD_807F;
  localparam logic [63:0] VEC1 = 64'h8005_3F40_FE03_817E;
`ifdef BLOB_REQUANT_RELU_EN
  localparam logic [63:0] EXP0_A = 64'h0100_0000_0100_0040;
  localparam logic [31:0] EXP0_B = 32'h1000_0007;
  localparam logic [63:0] EXP1_A = 64'h0003_2020_0002_003F;
  localparam logic [31:0] EXP1_B = 32'h0177_0107;
`else
  localparam logic [63:0] EXP0_A = 64'h0100_00E0_01FF_C040;
  localparam logic [31:0] EXP0_B = 32'h1008_0F87;
  localparam logic [63:0] EXP1_A = 64'hC003_2020_FF02_C13F;
  localparam logic [31:0] EXP1_B = 32'h8177_0187;
`endif

  typedef struct {
    logic        eop;
    logic [63:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_eop = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int out_cyc = 0;
  bit lat_armed = 0;
  bit lat_acc_seen = 0;
  bit lat_out_seen = 0;
  bit hand_valid;
  logic [63:0] hand_a;
  logic [31:0] hand_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lane model: floor(x / 2^s + 0.5) in real arithmetic, then clamp.
  function automatic int m_lane(input logic [7:0] b, input int s, input int w);
    int  x;
    int  y;
    real r;
    x = int'($signed(b));
    r = real'(x) / real'(2 ** s) + 0.5;
    y = int'($floor(r));
    if (y > (2 ** (w - 1)) - 1) y = (2 ** (w - 1)) - 1;
    if (y < -(2 ** (w - 1)))    y = -(2 ** (w - 1));
`ifdef BLOB_REQUANT_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  function automatic logic [63:0] model_a(input logic [63:0] d);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(m_lane(d[l*8 +: 8], 1, 8));
    return r;
  endfunction

  function automatic logic [31:0] model_b(input logic [63:0] d);
    logic [31:0] r;
    for (int l = 0; l < 8; l++) r[l*4 +: 4] = 4'(m_lane(d[l*8 +: 8], 2, 4));
    return r;
  endfunction

  function automatic logic [63:0] pat(input int k);
    logic [63:0] w;
    for (int l = 0; l < 8; l++) w[l*8 +: 8] = 8'(k * 29 + l * 71 + 13);
    return w;
  endfunction

  // Push expectation for every word the DUT will accept at the coming edge.
  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    if (!rst && din_en && rdy_a) begin
      ea.eop = din_eop;
      ea.d   = hand_valid ? hand_a : model_a(din);
      eb.eop = din_eop;
      eb.d   = {32'h0, (hand_valid ? hand_b : model_b(din))};
      qa.push_back(ea);
      qb.push_back(eb);
      n_acc++;
      if (lat_armed && !lat_acc_seen) begin
        lat_acc_seen = 1;
        acc_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && en_a) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_output actual=%h required=none", dout_a);
      end else begin
        e = qa.pop_front();
        check("a_data", dout_a, e.d);
        check("a_eop", 64'(eop_a), 64'(e.eop));
      end
      n_out++;
      if (eop_a) n_eop++;
      if (lat_armed && lat_acc_seen && !lat_out_seen) begin
        lat_out_seen = 1;
        out_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && en_b) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_output actual=%h required=none", dout_b);
      end else begin
        e = qb.pop_front();
        check("b_data", {32'h0, dout_b}, e.d);
        check("b_eop", 64'(eop_b), 64'(e.eop));
      end
    end
  end

  // Holds the word until accepted; caller is left 1 ns after the accepting edge.
  task automatic send(input logic [63:0] d, input logic eop, input bit hv,
                      input logic [63:0] ha, input logic [31:0] hb);
    bit acc;
    din = d; din_eop = eop; hand_valid = hv; hand_a = ha; hand_b = hb; din_en = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = rdy_a;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic raw_drive(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      din = pat(base + i); din_eop = 1'b0; hand_valid = 0; din_en = 1'b1;
      @(posedge clk);
      #1;
    end
    din_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    #1;
    check("drain_a_left", 64'(qa.size()), 64'd0);
    check("drain_b_left", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int e0;
    int a0;
    rst = 1'b1; din_en = 1'b0; din_eop = 1'b0; din = '0; dout_rdy = 1'b1;
    hand_valid = 0; hand_a = '0; hand_b = '0;
    #12;
    check("rst_dout_en", 64'(en_a), 64'd0);
    check("rst_dout", dout_a, 64'd0);
    check("rst_dout_eop", 64'(eop_a), 64'd0);
    check("rst_frame_err", 64'(err_a), 64'd0);
    check("rst_dout_b", {32'h0, dout_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_din_rdy", 64'(rdy_a), 64'd1);
    @(posedge clk);
    #1;

    // Full frame: two hand vectors then patterned words, eop on word 256.
    lat_armed = 1; n0 = n_out; e0 = n_eop;
    send(VEC0, 1'b0, 1, EXP0_A, EXP0_B);
    send(VEC1, 1'b0, 1, EXP1_A, EXP1_B);
    for (int k = 2; k < 256; k++) send(pat(k), (k == 255), 0, '0, '0);
    din_en = 1'b0;
    drain();
    check("first_latency", 64'(out_cyc - acc_cyc), 64'd2);
    check("frame_out_count", 64'(n_out - n0), 64'd256);
    check("frame_eop_count", 64'(n_eop - e0), 64'd1);
    check("frame_err_clean_a", 64'(err_a), 64'd0);
    check("frame_err_clean_b", 64'(err_b), 64'd0);
    lat_armed = 0;

    // Backpressure: only FIFO_DEPTH words get in.
    dout_rdy = 1'b0; a0 = n_acc;
    raw_drive(1000, 8);
    check("bp_accepted", 64'(n_acc - a0), 64'd4);
    check("bp_rdy_a", 64'(rdy_a), 64'd0);
    check("bp_rdy_b", 64'(rdy_b), 64'd0);
    check("bp_dout_en", 64'(en_a), 64'd0);
    n0 = n_out;
    dout_rdy = 1'b1;
    drain();
    check("bp_out_count", 64'(n_out - n0), 64'd4);

    // Early eop on word 100 of the frame (4 already counted), then missing eop.
    n0 = n_out;
    for (int k = 0; k < 96; k++) send(pat(2000 + k), (k == 95), 0, '0, '0);
    din_en = 1'b0;
    check("early_eop_err_a", 64'(err_a), 64'd1);
    check("early_eop_err_b", 64'(err_b), 64'd1);
    for (int k = 0; k < 256; k++) send(pat(3000 + k), 1'b0, 0, '0, '0);
    din_en = 1'b0;
    drain();
    check("err_sticky", 64'(err_a), 64'd1);
    check("err_words_out", 64'(n_out - n0), 64'd352);

    // Reset mid-frame with words in flight.
    dout_rdy = 1'b0;
    raw_drive(4000, 3);
    dout_rdy = 1'b1;
    #1;
    check("pre_rst_dout_en", 64'(en_a), 64'd1);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check("mid_rst_dout_en", 64'(en_a), 64'd0);
    check("mid_rst_dout", dout_a, 64'd0);
    check("mid_rst_frame_err", 64'(err_a), 64'd0);
    check("mid_rst_dout_en_b", 64'(en_b), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 64'(rdy_a), 64'd1);
    @(posedge clk);
    #1;
    n0 = n_out; e0 = n_eop;
    for (int k = 0; k < 256; k++) send(pat(5000 + k), (k == 255), 0, '0, '0);
    din_en = 1'b0;
    drain();
    check("post_rst_err_a", 64'(err_a), 64'd0);
    check("post_rst_err_b", 64'(err_b), 64'd0);
    check("post_rst_out_count", 64'(n_out - n0), 64'd256);
    check("post_rst_eop_count", 64'(n_eop - e0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
